// File: rtl/frv_ccx_pkg.sv
// Shared types for the chunk-serial CCX execution unit.
package frv_ccx_pkg;

    // Function select carried on ccx_sel_i.
    typedef enum logic [1:0] {
        CCX_MINU  = 2'd0,
        CCX_MAXU  = 2'd1,
        CCX_HAM   = 2'd2,
        CCX_CLMUL = 2'd3
    } ccx_fn_e;

    // Transfer/execute/stream-back sequencing.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EXEC    = 2'd2,
        EMIT    = 2'd3
    } ccx_state_e;

endpackage

// File: rtl/frv_ccx_clmul.sv
// Iterative carry-less multiplier, one multiplier bit per cycle.
// i_start processes bit 0 of i_b; o_done is high in the cycle that processes the
// last bit, with the final product already visible on o_result (next-state value).
// Only instantiated by frv_ccx_unit when FRV_CCX_CLMUL_EN is defined.
module frv_ccx_clmul #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned CntW      = (XLEN > 2) ? $clog2(XLEN) : 1;
    localparam int unsigned LastStepI = (XLEN > 1) ? XLEN - 2 : 0;
    localparam logic [CntW-1:0] LastStep = CntW'(LastStepI);

    logic            r_active, w_active_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [XLEN-1:0] r_acc, w_acc_d;
    logic [XLEN-1:0] r_ma, w_ma_d;
    logic [XLEN-1:0] r_mb, w_mb_d;

    // Next-state: load on start, then shift-XOR one multiplier bit per cycle.
    always_comb begin
        w_active_d = r_active;
        w_cnt_d    = r_cnt;
        w_acc_d    = r_acc;
        w_ma_d     = r_ma;
        w_mb_d     = r_mb;
        if (i_start) begin
            w_acc_d    = i_b[0] ? i_a : '0;
            w_ma_d     = i_a << 1;
            w_mb_d     = i_b >> 1;
            w_cnt_d    = '0;
            w_active_d = (XLEN > 1);
        end else if (r_active) begin
            w_acc_d = r_acc ^ (r_mb[0] ? r_ma : '0);
            w_ma_d  = r_ma << 1;
            w_mb_d  = r_mb >> 1;
            w_cnt_d = r_cnt + 1'b1;
            if (r_cnt == LastStep) begin
                w_active_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
        end else begin
            r_active <= w_active_d;
            r_cnt    <= w_cnt_d;
            r_acc    <= w_acc_d;
            r_ma     <= w_ma_d;
            r_mb     <= w_mb_d;
        end
    end

    assign o_done   = (i_start && (XLEN == 1)) || (r_active && (r_cnt == LastStep));
    assign o_result = w_acc_d;

endmodule

// File: rtl/frv_ccx_unit.sv
// Chunk-serial custom-compute unit for the FazyRV CCX port.
// Collects two XLEN-bit operands LSB chunk first, executes MINU/MAXU/HAM/CLMUL and
// streams the result back chunk-serially under ccx_resp_o.
// Optional feature macro: FRV_CCX_CLMUL_EN (without it, sel 3 returns zero after
// a single EXEC cycle).
module frv_ccx_unit
    import frv_ccx_pkg::*;
#(
    parameter int unsigned CHUNKSIZE = 4,
    parameter int unsigned XLEN      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ccx_req_i,
    input  logic [1:0]           ccx_sel_i,
    input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
    input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
    output logic [CHUNKSIZE-1:0] ccx_res_o,
    output logic                 ccx_resp_o,
    output logic                 busy_o
);

    localparam int unsigned NCHUNK = XLEN / CHUNKSIZE;
    localparam int unsigned CntW   = $clog2(NCHUNK + 1);
    localparam int unsigned HamW   = $clog2(XLEN + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

    ccx_state_e      r_state, w_state_d;
    ccx_fn_e         r_sel, w_sel_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [XLEN-1:0] r_a, w_a_d;
    logic [XLEN-1:0] r_b, w_b_d;
    logic [XLEN-1:0] r_res, w_res_d;

    logic [XLEN-1:0] w_a_shift, w_b_shift;
    logic [XLEN-1:0] w_minu, w_maxu, w_diff;
    logic [HamW-1:0] w_ham;

`ifdef FRV_CCX_CLMUL_EN
    logic            w_clmul_start;
    logic            w_clmul_done;
    logic [XLEN-1:0] w_clmul_res;

    frv_ccx_clmul #(
        .XLEN (XLEN)
    ) u_clmul (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_start  (w_clmul_start),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_done   (w_clmul_done),
        .o_result (w_clmul_res)
    );
`endif

    // Operand shift-in: move right by one chunk, new chunk enters at the top.
    always_comb begin
        w_a_shift = r_a >> CHUNKSIZE;
        w_b_shift = r_b >> CHUNKSIZE;
        w_a_shift[XLEN-1 -: CHUNKSIZE] = ccx_rs_a_i;
        w_b_shift[XLEN-1 -: CHUNKSIZE] = ccx_rs_b_i;
    end

    // Single-cycle functions on the assembled operands.
    always_comb begin
        w_minu = (r_a < r_b) ? r_a : r_b;
        w_maxu = (r_a < r_b) ? r_b : r_a;
        w_diff = r_a ^ r_b;
        w_ham  = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            w_ham = w_ham + HamW'(w_diff[i]);
        end
    end

    // Next-state and datapath control; r_cnt doubles as the CLMUL "started" flag in EXEC.
    always_comb begin
        w_state_d = r_state;
        w_sel_d   = r_sel;
        w_cnt_d   = r_cnt;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_res_d   = r_res;
`ifdef FRV_CCX_CLMUL_EN
        w_clmul_start = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (ccx_req_i) begin
                    w_a_d   = w_a_shift;
                    w_b_d   = w_b_shift;
                    w_sel_d = ccx_fn_e'(ccx_sel_i);
                    if (NCHUNK == 1) begin
                        w_state_d = EXEC;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = COLLECT;
                        w_cnt_d   = CntW'(1);
                    end
                end
            end
            COLLECT: begin
                if (ccx_req_i) begin
                    w_a_d = w_a_shift;
                    w_b_d = w_b_shift;
                    if (r_cnt == LastCnt) begin
                        w_state_d = EXEC;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end else begin
                    // Transfer broken off: drop partial operands silently.
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                    w_a_d     = '0;
                    w_b_d     = '0;
                end
            end
            EXEC: begin
                w_state_d = EMIT;
                w_cnt_d   = '0;
                unique case (r_sel)
                    CCX_MINU: w_res_d = w_minu;
                    CCX_MAXU: w_res_d = w_maxu;
                    CCX_HAM:  w_res_d = XLEN'(w_ham);
                    CCX_CLMUL: begin
`ifdef FRV_CCX_CLMUL_EN
                        w_clmul_start = (r_cnt == '0);
                        if (w_clmul_done) begin
                            w_res_d = w_clmul_res;
                        end else begin
                            w_state_d = EXEC;
                            w_cnt_d   = CntW'(1);
                        end
`else
                        w_res_d = '0;
`endif
                    end
                    default: w_res_d = '0;
                endcase
            end
            EMIT: begin
                w_res_d = r_res >> CHUNKSIZE;
                if (r_cnt == LastCnt) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_sel   <= CCX_MINU;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel_d;
            r_cnt   <= w_cnt_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_res   <= w_res_d;
        end
    end

    assign ccx_resp_o = (r_state == EMIT);
    assign ccx_res_o  = ccx_resp_o ? r_res[CHUNKSIZE-1:0] : '0;
    assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_frv_ccx_unit.sv
// Scoreboard bench for frv_ccx_unit (CHUNKSIZE=4, XLEN=32): the driver pushes the
// expected result chunks with their expected cycle numbers; a negedge monitor pops
// and compares whenever ccx_resp_o is high.
module tb_frv_ccx_unit;

    localparam int unsigned CS     = 4;
    localparam int unsigned XL     = 32;
    localparam int unsigned NCHUNK = XL / CS;
`ifdef FRV_CCX_CLMUL_EN
    localparam bit ClmulEn = 1'b1;
`else
    localparam bit ClmulEn = 1'b0;
`endif

    typedef struct {
        logic [CS-1:0] chunk;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic [CS-1:0] rs_a = '0;
    logic [CS-1:0] rs_b = '0;
    logic [CS-1:0] res;
    logic          resp;
    logic          busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    exp_t exp_q[$];

    frv_ccx_unit #(
        .CHUNKSIZE (CS),
        .XLEN      (XL)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ccx_req_i  (req),
        .ccx_sel_i  (sel),
        .ccx_rs_a_i (rs_a),
        .ccx_rs_b_i (rs_b),
        .ccx_res_o  (res),
        .ccx_resp_o (resp),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour straight from the function definitions.
    function automatic logic [XL-1:0] ref_model(input logic [1:0] f, input logic [XL-1:0] a,
                                                input logic [XL-1:0] b);
        logic [XL-1:0] p;
        case (f)
            2'd0: return (a < b) ? a : b;
            2'd1: return (a > b) ? a : b;
            2'd2: return XL'($countones(a ^ b));
            default: begin
                p = '0;
                if (ClmulEn) begin
                    for (int i = 0; i < int'(XL); i++) begin
                        if (b[i]) p = p ^ (a << i);
                    end
                end
                return p;
            end
        endcase
    endfunction

    // Issue one transfer. n_sent < NCHUNK models an aborted transfer (no response).
    task automatic do_op(input logic [1:0] f, input logic [XL-1:0] a, input logic [XL-1:0] b,
                         input int n_sent, input bit scramble, input int hold,
                         output int t0);
        int            w;
        int            first;
        logic [XL-1:0] r;
        exp_t          e;
        w = 0;
        while (busy && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL idle_wait busy=%0b required=0", busy);
        end
        t0 = cyc;
        if (n_sent == int'(NCHUNK)) begin
            r     = ref_model(f, a, b);
            first = t0 + int'(NCHUNK) + ((f == 2'd3 && ClmulEn) ? int'(XL) : 1);
            for (int k = 0; k < int'(NCHUNK); k++) begin
                e.chunk = r[CS*k +: CS];
                e.cyc   = first + k;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < n_sent; i++) begin
            req  = 1'b1;
            sel  = (i == 0 || !scramble) ? f : 2'($urandom);
            rs_a = a[CS*i +: CS];
            rs_b = b[CS*i +: CS];
            @(posedge clk);
            #1;
        end
        // Requests while busy must be ignored.
        for (int i = 0; i < hold; i++) begin
            req  = 1'b1;
            sel  = 2'($urandom);
            rs_a = CS'($urandom);
            rs_b = CS'($urandom);
            @(posedge clk);
            #1;
        end
        req  = 1'b0;
        rs_a = '0;
        rs_b = '0;
    endtask

    // Monitor: compare each response chunk and its cycle; res must be 0 when idle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missed_resp cycle=%0d required_chunk=%h", e.cyc, e.chunk);
                end
                checks++;
                if (resp) begin
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_resp cycle=%0d res=%h required=none", cyc, res);
                    end else begin
                        e = exp_q.pop_front();
                        if (res !== e.chunk || cyc != e.cyc) begin
                            failures++;
                            $display("FAIL resp_chunk cycle=%0d res=%h required cycle=%0d res=%h",
                                     cyc, res, e.cyc, e.chunk);
                        end
                    end
                end else if (res !== '0) begin
                    failures++;
                    $display("FAIL res_idle cycle=%0d res=%h required=0", cyc, res);
                end
            end
        end
    end

    initial begin
        int            t0;
        int            w;
        logic [1:0]    f;
        logic [XL-1:0] a;
        logic [XL-1:0] b;
        int            n;
        int            hold;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (resp !== 1'b0 || res !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state resp=%b res=%h busy=%b required 0 0 0", resp, res, busy);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Directed cases.
        do_op(2'd0, 32'h0000_0010, 32'h0000_0008, NCHUNK, 1'b0, 0, t0);
        do_op(2'd2, 32'hFFFF_FFFF, 32'h0000_0000, NCHUNK, 1'b0, 0, t0);
        do_op(2'd3, 32'h0000_0003, 32'h0000_0003, NCHUNK, 1'b0, 0, t0);

        // Abort after three chunks: no response, back to idle.
        do_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 3, 1'b0, 0, t0);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle busy=%b required=0", busy);
        end
        do_op(2'd1, 32'h0000_0001, 32'hFFFF_FFFF, NCHUNK, 1'b0, 0, t0);

        // Reset during the second EMIT chunk.
        do_op(2'd0, 32'h0000_0010, 32'h0000_0008, NCHUNK, 1'b0, 0, t0);
        w = 0;
        while (cyc < t0 + int'(NCHUNK) + 2 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (resp !== 1'b0 || res !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_emit resp=%b res=%h busy=%b required 0 0 0", resp, res, busy);
        end
        do_op(2'd2, 32'hA5A5_0F0F, 32'h5A5A_0FF0, NCHUNK, 1'b0, 0, t0);

        // Select changed mid-collect and request held into EXEC/EMIT.
        do_op(2'd0, 32'h8000_0001, 32'h7FFF_FFFF, NCHUNK, 1'b1, 8, t0);
        do_op(2'd3, 32'hDEAD_BEEF, 32'h0F0F_1234, NCHUNK, 1'b1, 8, t0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            f = 2'($urandom);
            a = $urandom;
            b = (k % 5 == 0) ? a : $urandom;
            if (k % 7 == 3) a = '0;
            if ($urandom_range(0, 6) == 0) begin
                n    = $urandom_range(1, NCHUNK - 1);
                hold = 0;
            end else begin
                n    = NCHUNK;
                hold = $urandom_range(0, 8);
            end
            do_op(f, a, b, n, 1'($urandom), hold, t0);
        end

        w = 0;
        while (exp_q.size() > 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL final_idle busy=%b required=0", busy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
